// File: rtl/cmip_fifo_burst_rd_pkg.sv
// Shared types and sizing helpers for the cmip_fifo_burst_rd drain stage.
// Optional partial-burst timeout is controlled by macro CMIP_FIFO_BURST_RD_TMO_EN.
package cmip_fifo_burst_rd_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Width of the completed-burst counter.
  localparam int BURST_CNT_WDTH = 16;

  // Beat counter must hold values 0..burst_len inclusive.
  function automatic int beat_cnt_wdth(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

endpackage

// File: rtl/cmip_burst_tmo_timer.sv
// Partial-burst timeout counter: counts while enabled, clears on clr,
// flags expiry on the cycle the count reaches th-1. A threshold of 0 never expires.
// Used by cmip_fifo_burst_rd only when CMIP_FIFO_BURST_RD_TMO_EN is defined.
module cmip_burst_tmo_timer #(
  parameter int TMO_WDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                en,
  input  logic [TMO_WDTH-1:0] th,
  output logic                expire
);

  logic [TMO_WDTH-1:0] cnt;

  // Counter register: synchronous clear has priority over counting.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Expiry is qualified by en so a stale count never fires outside the window.
  always_comb begin
    expire = en && (th != '0) && (cnt == (th - 1'b1));
  end

endmodule

// File: rtl/cmip_fifo_burst_rd.sv
// Read-side drain stage for an FWFT async FIFO: pops words and emits them as
// sop/eop-framed bursts on a valid/ready stream.
// Handshake: a beat transfers on any rising edge where o_vld=1 and i_rdy=1;
// while o_vld=1 and i_rdy=0 the beat (o_data/o_sop/o_eop) is held unchanged.
// FIFO side: o_fifo_rd pops the FWFT head in the same cycle it is captured.
// Optional macro CMIP_FIFO_BURST_RD_TMO_EN adds a timeout that flushes partial bursts.
// FSM state is visible externally through o_busy (1 = ST_BURST).
module cmip_fifo_burst_rd
  import cmip_fifo_burst_rd_pkg::*;
#(
  parameter int DATA_WDTH = 512,
  parameter int ADDR_WDTH = 5,
  parameter int BURST_LEN = 8,
  parameter int TMO_WDTH  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_fifo_empty,
  input  logic [ADDR_WDTH:0]        i_fifo_rd_cnt,
  input  logic [DATA_WDTH-1:0]      i_fifo_dout,
  output logic                      o_fifo_rd,
  input  logic [TMO_WDTH-1:0]       i_tmo_th,
  output logic                      o_vld,
  input  logic                      i_rdy,
  output logic [DATA_WDTH-1:0]      o_data,
  output logic                      o_sop,
  output logic                      o_eop,
  output logic                      o_busy,
  output logic [BURST_CNT_WDTH-1:0] o_burst_cnt
);

  localparam int BL_W  = beat_cnt_wdth(BURST_LEN);
  localparam int CNT_W = ADDR_WDTH + 1;

  state_t          state, state_nxt;
  logic [BL_W-1:0] beats_left;
  logic [BL_W-1:0] burst_len_q;
  logic [BL_W-1:0] start_len;
  logic            start;
  logic            load;
  logic            eop_acc;
  logic            full_avail;

  assign full_avail = (i_fifo_rd_cnt >= CNT_W'(BURST_LEN));
  assign load       = (state == ST_BURST) && (beats_left != '0) && !i_fifo_empty &&
                      (!o_vld || i_rdy);
  assign eop_acc    = o_vld && i_rdy && o_eop;
  assign o_fifo_rd  = load;
  assign o_busy     = (state == ST_BURST);

`ifdef CMIP_FIFO_BURST_RD_TMO_EN
  logic tmo_en;
  logic tmo_expire;

  // Timer runs only while a partial amount of data sits in the FIFO in IDLE.
  always_comb begin
    tmo_en = (state == ST_IDLE) && (i_fifo_rd_cnt != '0) && !full_avail;
  end

  cmip_burst_tmo_timer #(
    .TMO_WDTH (TMO_WDTH)
  ) u_tmo (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clr    (!tmo_en),
    .en     (tmo_en),
    .th     (i_tmo_th),
    .expire (tmo_expire)
  );
`else
  logic tmo_th_unused;
  assign tmo_th_unused = ^i_tmo_th;
`endif

  // Next-state logic: full burst has priority over a coinciding timeout.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    start_len = '0;
    case (state)
      ST_IDLE: begin
        if (full_avail) begin
          state_nxt = ST_BURST;
          start     = 1'b1;
          start_len = BL_W'(BURST_LEN);
        end
`ifdef CMIP_FIFO_BURST_RD_TMO_EN
        else if (tmo_expire) begin
          state_nxt = ST_BURST;
          start     = 1'b1;
          start_len = BL_W'(i_fifo_rd_cnt);
        end
`endif
      end
      ST_BURST: begin
        if ((beats_left == '0) && eop_acc) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Beat bookkeeping: remaining beats and the length of the current burst.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      beats_left  <= '0;
      burst_len_q <= '0;
    end else if (start) begin
      beats_left  <= start_len;
      burst_len_q <= start_len;
    end else if (load) begin
      beats_left  <= beats_left - 1'b1;
    end
  end

  // Output register: loads a popped word, holds while stalled, drains on accept.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_vld  <= 1'b0;
      o_data <= '0;
      o_sop  <= 1'b0;
      o_eop  <= 1'b0;
    end else if (load) begin
      o_vld  <= 1'b1;
      o_data <= i_fifo_dout;
      o_sop  <= (beats_left == burst_len_q);
      o_eop  <= (beats_left == BL_W'(1));
    end else if (i_rdy) begin
      o_vld  <= 1'b0;
      o_sop  <= 1'b0;
      o_eop  <= 1'b0;
    end
  end

  // Completed-burst counter; wraps naturally at its width.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_burst_cnt <= '0;
    end else if (eop_acc) begin
      o_burst_cnt <= o_burst_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cmip_fifo_burst_rd.sv
// Bench for cmip_fifo_burst_rd: FWFT FIFO model, scoreboard of expected beats,
// vector table for full-burst traffic plus hand sequences for stall, residual,
// timeout (CMIP_FIFO_BURST_RD_TMO_EN) and mid-burst reset.
module tb_cmip_fifo_burst_rd;

  localparam int DW = 512;
  localparam int AW = 5;
  localparam int BL = 8;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          i_rst_n;
  logic          i_fifo_empty;
  logic [AW:0]   i_fifo_rd_cnt;
  logic [DW-1:0] i_fifo_dout;
  logic          o_fifo_rd;
  logic [TW-1:0] i_tmo_th;
  logic          o_vld;
  logic          i_rdy;
  logic [DW-1:0] o_data;
  logic          o_sop;
  logic          o_eop;
  logic          o_busy;
  logic [15:0]   o_burst_cnt;

  cmip_fifo_burst_rd #(
    .DATA_WDTH (DW),
    .ADDR_WDTH (AW),
    .BURST_LEN (BL),
    .TMO_WDTH  (TW)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_fifo_empty  (i_fifo_empty),
    .i_fifo_rd_cnt (i_fifo_rd_cnt),
    .i_fifo_dout   (i_fifo_dout),
    .o_fifo_rd     (o_fifo_rd),
    .i_tmo_th      (i_tmo_th),
    .o_vld         (o_vld),
    .i_rdy         (i_rdy),
    .o_data        (o_data),
    .o_sop         (o_sop),
    .o_eop         (o_eop),
    .o_busy        (o_busy),
    .o_burst_cnt   (o_burst_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_bad    = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wr_q[$];
  logic [DW+1:0] exp_q[$];   // {sop, eop, data}

  int   cyc         = 0;
  int   write_cyc   = 0;
  int   rdy_mode    = 0;     // 0: always ready, 1: toggle, 2: random
  logic cnt_force   = 1'b0;  // report rd_cnt=BL regardless of contents
  logic pop_pending = 1'b0;
  int   beat_idx    = 0;
  int   exp_bursts  = 0;

  int   pops, vld_seen, acc_cnt, busy_cycles, first_pop, first_vld;

  logic          hold_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_sop, prev_eop;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // ---------------- driver + monitor (negedge, sample at +1) ----------------
  always @(negedge clk) begin
    cyc++;
    if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_pending = 1'b0;
    if (wr_q.size() > 0) begin
      write_cyc = cyc;
      while (wr_q.size() > 0) fifo_q.push_back(wr_q.pop_front());
    end
    case (rdy_mode)
      0:       i_rdy = 1'b1;
      1:       i_rdy = ~i_rdy;
      default: i_rdy = 1'($urandom_range(0, 1));
    endcase
    i_fifo_empty  = (fifo_q.size() == 0);
    i_fifo_rd_cnt = cnt_force ? (AW+1)'(BL) : (AW+1)'(fifo_q.size());
    i_fifo_dout   = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    #1;
    if (i_rst_n) begin
      if (o_busy) busy_cycles++;
      if (o_fifo_rd) begin
        pops++;
        if (first_pop < 0) first_pop = cyc;
        chk("pop_while_empty", 64'(i_fifo_empty), 0);
        chk("pop_while_stalled", 64'(o_vld && !i_rdy), 0);
        pop_pending = 1'b1;
      end
      if (o_vld) begin
        vld_seen++;
        if (first_vld < 0) first_vld = cyc;
      end
      if (hold_prev) begin
        chk("hold_vld", 64'(o_vld), 1);
        chk("hold_data", 64'(o_data != prev_data), 0);
        chk("hold_sop", 64'(o_sop), 64'(prev_sop));
        chk("hold_eop", 64'(o_eop), 64'(prev_eop));
      end
      if (o_vld && i_rdy) begin
        acc_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL beat_unexpected: got beat sop=%0b eop=%0b with empty expected queue (cycle %0d)",
                   o_sop, o_eop, cyc);
        end else begin
          logic [DW+1:0] e;
          e = exp_q.pop_front();
          if ({o_sop, o_eop, o_data} !== e) begin
            n_bad++;
            $display("FAIL beat: got sop=%0b eop=%0b data[31:0]=%08h expected sop=%0b eop=%0b data[31:0]=%08h (cycle %0d)",
                     o_sop, o_eop, o_data[31:0], e[DW+1], e[DW], e[31:0], cyc);
          end
        end
      end
      hold_prev = o_vld && !i_rdy;
      prev_data = o_data;
      prev_sop  = o_sop;
      prev_eop  = o_eop;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---------------- stimulus tasks (run at posedge+2) ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic arm();
    pops = 0; vld_seen = 0; acc_cnt = 0; busy_cycles = 0;
    first_pop = -1; first_vld = -1;
  endtask

  // Words that belong to back-to-back full bursts.
  task automatic write_full(input int n);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] w;
      w = rand_word();
      wr_q.push_back(w);
      exp_q.push_back({1'(beat_idx == 0), 1'(beat_idx == BL - 1), w});
      beat_idx = (beat_idx + 1) % BL;
    end
  endtask

  // Words that form one standalone partial burst.
  task automatic write_partial(input int n);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] w;
      w = rand_word();
      wr_q.push_back(w);
      exp_q.push_back({1'(i == 0), 1'(i == n - 1), w});
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && !o_vld && !o_busy) && t < budget) begin
      tick();
      t++;
    end
    chk(name, 64'(t < budget), 1);
  endtask

  task automatic reset_and_flush();
    i_rst_n = 1'b0;
    tick();
    tick();
    fifo_q.delete();
    wr_q.delete();
    exp_q.delete();
    beat_idx   = 0;
    exp_bursts = 0;
    i_rst_n    = 1'b1;
    tick();
  endtask

  typedef struct {
    int n_words;
    int rdy_mode;
    int bursts;
    int pops;
  } vec_t;

  vec_t vecs[4];

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{n_words: 8,  rdy_mode: 0, bursts: 1, pops: 8};
    vecs[1] = '{n_words: 16, rdy_mode: 1, bursts: 2, pops: 16};
    vecs[2] = '{n_words: 24, rdy_mode: 2, bursts: 3, pops: 24};
    vecs[3] = '{n_words: 8,  rdy_mode: 2, bursts: 1, pops: 8};

    i_rst_n  = 1'b0;
    i_rdy    = 1'b1;
    i_tmo_th = '0;
    arm();
    repeat (3) tick();

    chk("rst_vld",   64'(o_vld), 0);
    chk("rst_sop",   64'(o_sop), 0);
    chk("rst_eop",   64'(o_eop), 0);
    chk("rst_data",  64'(o_data != '0), 0);
    chk("rst_busy",  64'(o_busy), 0);
    chk("rst_bcnt",  64'(o_burst_cnt), 0);
    chk("rst_rd",    64'(o_fifo_rd), 0);
    i_rst_n = 1'b1;
    tick();

    // Full-burst traffic under different ready patterns.
    for (int v = 0; v < 4; v++) begin
      rdy_mode = vecs[v].rdy_mode;
      arm();
      write_full(vecs[v].n_words);
      wait_drain("vec_drain", 2000);
      exp_bursts += vecs[v].bursts;
      chk("vec_bcnt", 64'(o_burst_cnt), 64'(exp_bursts));
      chk("vec_pops", 64'(pops), 64'(vecs[v].pops));
      chk("vec_fifo_left", 64'(fifo_q.size()), 0);
      if (v == 0) begin
        chk("lat_first_pop", 64'(first_pop - write_cyc), 1);
        chk("lat_first_vld", 64'(first_vld - write_cyc), 2);
        chk("busy_cycles", 64'(busy_cycles), 64'(BL + 1));
      end
    end

    // Fewer than BURST_LEN words with no timeout: nothing comes out.
    rdy_mode = 0;
    i_tmo_th = '0;
    arm();
    write_partial(5);
    repeat (1000) tick();
    chk("resid_vld_seen", 64'(vld_seen), 0);
    chk("resid_pops", 64'(pops), 0);
    chk("resid_fifo", 64'(fifo_q.size()), 5);
    reset_and_flush();
    chk("flush_bcnt", 64'(o_burst_cnt), 0);

`ifdef CMIP_FIFO_BURST_RD_TMO_EN
    // Partial burst flushed by the timeout.
    i_tmo_th = 16'd100;
    arm();
    write_partial(3);
    wait_drain("tmo_drain", 400);
    exp_bursts++;
    chk("tmo_latency", 64'(first_pop - write_cyc), 100);
    chk("tmo_pops", 64'(pops), 3);
    chk("tmo_bcnt", 64'(o_burst_cnt), 64'(exp_bursts));
    i_tmo_th = '0;
    tick();
`endif

    // FIFO count lags: burst starts on a reported 8 with only 4 words present.
    rdy_mode = 0;
    arm();
    cnt_force = 1'b1;
    write_full(4);
    begin
      int t;
      t = 0;
      while (!o_busy && t < 50) begin
        tick();
        t++;
      end
      chk("stall_started", 64'(o_busy), 1);
    end
    cnt_force = 1'b0;
    repeat (20) tick();
    chk("stall_vld", 64'(o_vld), 0);
    chk("stall_busy", 64'(o_busy), 1);
    chk("stall_acc", 64'(acc_cnt), 4);
    write_full(4);
    wait_drain("stall_drain", 200);
    exp_bursts++;
    chk("stall_bcnt", 64'(o_burst_cnt), 64'(exp_bursts));
    chk("stall_pops", 64'(pops), 8);

    // Reset on beat 3 of a burst, then a clean burst afterwards.
    rdy_mode = 0;
    arm();
    write_full(8);
    begin
      int t;
      t = 0;
      while (acc_cnt < 3 && t < 50) begin
        tick();
        t++;
      end
      chk("mid_reached_beat3", 64'(acc_cnt), 3);
    end
    i_rst_n = 1'b0;
    tick();
    chk("mid_rst_vld",  64'(o_vld), 0);
    chk("mid_rst_sop",  64'(o_sop), 0);
    chk("mid_rst_eop",  64'(o_eop), 0);
    chk("mid_rst_data", 64'(o_data != '0), 0);
    chk("mid_rst_busy", 64'(o_busy), 0);
    chk("mid_rst_bcnt", 64'(o_burst_cnt), 0);
    chk("mid_rst_rd",   64'(o_fifo_rd), 0);
    fifo_q.delete();
    exp_q.delete();
    beat_idx   = 0;
    exp_bursts = 0;
    i_rst_n    = 1'b1;
    tick();
    arm();
    write_full(8);
    wait_drain("post_rst_drain", 200);
    exp_bursts++;
    chk("post_rst_bcnt", 64'(o_burst_cnt), 64'(exp_bursts));
    chk("post_rst_pops", 64'(pops), 8);

    chk("exp_q_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
